// File: rtl/ef_smsdac_dsm.sv
// ef_smsdac_dsm: input sample-and-hold, second-order error-feedback delta-sigma
// requantizer to a 9-bit half-LSB code, and the random-bit LFSR that feeds the
// segmented mismatch-shaping encoder.
module ef_smsdac_dsm #(
    parameter int          OSR  = 16,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic        clr_flags,
    output logic        x7,
    output logic [6:0]  x,
    output logic        x_c,
    output logic [6:0]  r,
    output logic        ovf,
    output logic        underrun
);

    localparam int            CW      = (OSR > 1) ? $clog2(OSR) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(OSR - 1);

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [15:0]         hold_q, hold_d;
    logic [6:0]          e1_q, e1_d;
    logic [6:0]          e2_q, e2_d;
    logic [8:0]          q9_q, q9_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic                ovf_q, ovf_d;
    logic                und_q, und_d;

    logic [15:0]         v;
    logic signed [17:0]  w;
    logic signed [17:0]  qf;
    logic                sat_lo, sat_hi, sat;
    logic [8:0]          q;

    // Modulator datapath: offset-binary sample plus shaped error, then quantize.
    always_comb begin
        v      = {~hold_q[15], hold_q[14:0]};
        w      = $signed({2'b00, v}) + $signed({10'b0, e1_q, 1'b0})
                 - $signed({11'b0, e2_q});
        qf     = w >>> 7;
        // w never exceeds 2^17, so qf[17] alone flags a negative quotient.
        sat_lo = qf[17];
        sat_hi = ~qf[17] & (|qf[16:9]);
        sat    = sat_lo | sat_hi;
        if (sat_lo) begin
            q = 9'd0;
        end else if (sat_hi) begin
            q = 9'd511;
        end else begin
            q = qf[8:0];
        end
    end

    assign din_ready = en & (cnt_q == '0);

    // Next-state for counter, hold register, error feedback, LFSR and flags.
    always_comb begin
        cnt_d  = cnt_q;
        hold_d = hold_q;
        e1_d   = e1_q;
        e2_d   = e2_q;
        q9_d   = q9_q;
        lfsr_d = lfsr_q;
        ovf_d  = ovf_q;
        und_d  = und_q;
        if (en) begin
            cnt_d  = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
            q9_d   = q;
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            if (clr_flags) begin
                ovf_d = 1'b0;
                und_d = 1'b0;
            end
            if (sat) begin
                e1_d  = 7'd0;
                e2_d  = 7'd0;
                ovf_d = 1'b1;
            end else begin
                // Unsaturated residue w - q*128 is just the low 7 bits of w.
                e1_d = w[6:0];
                e2_d = e1_q;
            end
            if (din_ready) begin
                if (din_valid) begin
                    hold_d = din;
                end else begin
                    und_d = 1'b1;
                end
            end
        end
    end

    // State registers with asynchronous reset to midscale / seed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            hold_q <= 16'd0;
            e1_q   <= 7'd0;
            e2_q   <= 7'd0;
            q9_q   <= 9'd256;
            lfsr_q <= SEED;
            ovf_q  <= 1'b0;
            und_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            hold_q <= hold_d;
            e1_q   <= e1_d;
            e2_q   <= e2_d;
            q9_q   <= q9_d;
            lfsr_q <= lfsr_d;
            ovf_q  <= ovf_d;
            und_q  <= und_d;
        end
    end

    assign x7       = q9_q[8];
    assign x        = q9_q[7:1];
    assign x_c      = q9_q[0];
    assign r        = lfsr_q[6:0];
    assign ovf      = ovf_q;
    assign underrun = und_q;

endmodule

// File: tb/tb_ef_smsdac_dsm.sv
// Bench for ef_smsdac_dsm: arithmetic reference model plus directed stimulus.
module tb_ef_smsdac_dsm;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               en = 1'b0;
    logic signed [15:0] din = '0;
    logic               din_valid = 1'b0;
    logic               din_ready;
    logic               clr_flags = 1'b0;
    logic               x7;
    logic [6:0]         x;
    logic               x_c;
    logic [6:0]         r;
    logic               ovf;
    logic               underrun;

    int total = 0;
    int bad = 0;

    // reference model state (plain integers)
    int m_cnt = 0, m_hold = 0, m_e1 = 0, m_e2 = 0, m_q = 256;
    int m_lfsr = 16'hACE1, m_ovf = 0, m_und = 0;

    ef_smsdac_dsm #(.OSR(16), .SEED(16'hACE1)) dut (
        .clk(clk), .rst(rst), .en(en), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .clr_flags(clr_flags), .x7(x7), .x(x),
        .x_c(x_c), .r(r), .ovf(ovf), .underrun(underrun)
    );

    always #10 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int q9_now();
        return int'({x7, x, x_c});
    endfunction

    // model: one step per enabled edge, computed from the arithmetic definition
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_cnt = 0; m_hold = 0; m_e1 = 0; m_e2 = 0; m_q = 256;
            m_lfsr = 16'hACE1; m_ovf = 0; m_und = 0;
        end else if (en) begin
            int w, qf, qc, fb;
            bit sat, rdy;
            rdy = (m_cnt == 0);
            w   = (m_hold + 32768) + 2 * m_e1 - m_e2;
            qf  = (w >= 0) ? (w / 128) : -((-w + 127) / 128);
            sat = (qf < 0) || (qf > 511);
            qc  = (qf < 0) ? 0 : ((qf > 511) ? 511 : qf);
            if (sat) begin
                m_e1 = 0; m_e2 = 0;
            end else begin
                m_e2 = m_e1;
                m_e1 = w - qc * 128;
            end
            m_q = qc;
            if (clr_flags) begin m_ovf = 0; m_und = 0; end
            if (sat) m_ovf = 1;
            if (rdy) begin
                if (din_valid) m_hold = int'(din);
                else m_und = 1;
            end
            m_cnt = (m_cnt + 1) % 16;
            fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
            m_lfsr = ((m_lfsr << 1) & 16'hFFFF) | fb;
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("q9", q9_now(), m_q);
            chk("r", int'(r), m_lfsr & 127);
            chk("ovf", int'(ovf), m_ovf);
            chk("underrun", int'(underrun), m_und);
            chk("din_ready", int'(din_ready), (en && m_cnt == 0) ? 1 : 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int cnt_rdy, cnt_xc, cnt_bad_hi, q_save, r_save, guard;

        // reset state
        #1 rst = 1'b1;
        #3;
        chk("rst_q9", q9_now(), 256);
        chk("rst_r", int'(r), 7'h61);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_und", int'(underrun), 0);
        rst = 1'b0;
        en = 1'b1; din_valid = 1'b1; din = 16'sd0;
        #1 chk("rst_ready", int'(din_ready), 1);

        // first enabled edge: LFSR advance
        @(negedge clk);
        chk("lfsr_step1", int'(r), 7'h43);

        // din=0: midscale, one ready per 16 cycles
        cnt_rdy = 0;
        repeat (48) begin
            @(negedge clk);
            if (din_ready) cnt_rdy++;
            chk("zero_q9", q9_now(), 256);
        end
        chk("ready_rate", cnt_rdy, 3);

        // din=64: x_c toggles with mean 0.5
        tick(1); din = 16'sd64;
        tick(24);
        cnt_xc = 0; cnt_bad_hi = 0;
        repeat (256) begin
            @(negedge clk);
            if (x_c) cnt_xc++;
            if (!x7 || x != 7'd0) cnt_bad_hi++;
        end
        chk("xc_mean", cnt_xc, 128);
        chk("small_hi_bits", cnt_bad_hi, 0);
        chk("small_ovf", int'(ovf), 0);

        // full-scale positive: saturation and sticky ovf
        tick(1); din = 16'sd32767;
        tick(64);
        @(negedge clk);
        chk("fs_q9", q9_now(), 511);
        chk("fs_ovf", int'(ovf), 1);
        tick(1); clr_flags = 1'b1;
        tick(1); clr_flags = 1'b0;
        tick(3);

        // a few more operating points, flags cleared in between
        din = -16'sd32768; tick(40);
        @(negedge clk);
        chk("neg_fs_q9", q9_now(), 0);
        tick(1); clr_flags = 1'b1;
        tick(1); clr_flags = 1'b0;
        din = 16'sd12345; tick(40);
        din = -16'sd20000; tick(40);
        din = 16'sd5; tick(1);
        clr_flags = 1'b1; tick(1); clr_flags = 1'b0;

        // underrun: one missed ready slot, then a valid capture
        din_valid = 1'b0; din = 16'sd999;
        tick(16);
        @(negedge clk);
        chk("und_set", int'(underrun), 1);
        tick(1); din_valid = 1'b1; din = 16'sd777;
        tick(20);
        chk("und_sticky", int'(underrun), 1);
        clr_flags = 1'b1; tick(1); clr_flags = 1'b0;
        @(negedge clk);
        chk("und_clr", int'(underrun), 0);

        // en=0 freeze, clr_flags ignored while frozen
        tick(1);
        din_valid = 1'b0; tick(16); din_valid = 1'b1;
        en = 1'b0; clr_flags = 1'b1;
        q_save = q9_now(); r_save = int'(r);
        tick(10);
        chk("frz_q9", q9_now(), q_save);
        chk("frz_r", int'(r), r_save);
        chk("frz_und", int'(underrun), 1);
        chk("frz_ready", int'(din_ready), 0);
        clr_flags = 1'b0; en = 1'b1;
        tick(5);

        // asynchronous reset while cnt==7
        guard = 0;
        while (m_cnt != 7 && guard < 32) begin
            tick(1);
            guard++;
        end
        chk("cnt7_reached", (m_cnt == 7) ? 1 : 0, 1);
        #1 rst = 1'b1;
        #1;
        chk("arst_q9", q9_now(), 256);
        chk("arst_r", int'(r), 7'h61);
        chk("arst_und", int'(underrun), 0);
        rst = 1'b0;
        #1 chk("arst_ready", int'(din_ready), 1);
        din = 16'sd3000;
        tick(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
